// File: rtl/disto_nxn_pipe.sv
// disto_nxn_pipe: weighted WHT texture distortion or SSE between two NxN blocks, LANES tiles per cycle
module disto_nxn_pipe #(
  parameter int BLOCK_SIZE = 16,
  parameter int LANES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic mode,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] ina,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] inb,
  input  logic [255:0] w,
  output logic [31:0] sum,
  output logic busy,
  output logic done
);
  localparam int TPR = BLOCK_SIZE / 4;
  localparam int NSB = TPR * TPR;
  localparam int G = NSB / LANES;
  localparam int CW = G > 1 ? $clog2(G) : 1;
  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0] a_q, b_q;
  logic [255:0] w_q;
  logic mode_q;
  logic accept, issuing, v1, v2, v3, l1, l2, l3, l4;
  logic [CW-1:0] cnt;
  logic [31:0] acc, lane_sum;
  logic [31:0] lane_res [LANES];
  assign accept = start & ~busy;
  // One output of the 4-point butterfly; k selects the output index
  function automatic int bf(input int x0, input int x1, input int x2, input int x3, input int k);
    int a0, a1, a2, a3;
    a0 = x0 + x2;
    a1 = x1 + x3;
    a2 = x1 - x3;
    a3 = x0 - x2;
    return k == 0 ? a0 + a1 : k == 1 ? a3 + a2 : k == 2 ? a3 - a2 : a0 - a1;
  endfunction
  // Operand capture so callers may change inputs right after the accept edge
  always_ff @(posedge clk)
    if (accept) begin
      a_q <= ina;
      b_q <= inb;
      w_q <= w;
      mode_q <= mode;
    end
  // Issue counter, stage valids, accumulator and result/handshake registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      acc <= '0;
      cnt <= '0;
      issuing <= 1'b0;
      {v1, v2, v3, l1, l2, l3, l4} <= '0;
    end else begin
      done <= 1'b0;
      v1 <= issuing;
      l1 <= issuing && cnt == CW'(G - 1);
      v2 <= v1;
      l2 <= l1;
      v3 <= v2;
      l3 <= l2;
      l4 <= v3 && l3;
      if (issuing) begin
        cnt <= cnt == CW'(G - 1) ? '0 : cnt + 1'b1;
        issuing <= cnt != CW'(G - 1);
      end
      if (v3) acc <= acc + lane_sum;
      if (accept) begin
        busy <= 1'b1;
        issuing <= 1'b1;
        cnt <= '0;
        acc <= '0;
      end
      if (l4) begin
        sum <= acc;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int tile;
    int pa [16], pb [16];
    logic signed [10:0] ha_d [16], hb_d [16], ha_q [16], hb_q [16];
    logic [31:0] s2a_d, s2b_d, s2a_q, s2b_q, res_d, res_q;
    assign tile = int'(cnt) * LANES + l;
    assign lane_res[l] = res_q;
    // Gather the 16 pixels of this lane's tile from the captured blocks
    always_comb
      for (int i = 0; i < 16; i++) begin
        pa[i] = int'(a_q[8*((4*(tile/TPR) + i/4)*BLOCK_SIZE + 4*(tile%TPR) + i%4) +: 8]);
        pb[i] = int'(b_q[8*((4*(tile/TPR) + i/4)*BLOCK_SIZE + 4*(tile%TPR) + i%4) +: 8]);
      end
    // S1: row transforms of A and B, or the signed pixel difference in SSE mode
    always_comb
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ha_d[4*r+c] = 11'(mode_q ? pa[4*r+c] - pb[4*r+c] : bf(pa[4*r], pa[4*r+1], pa[4*r+2], pa[4*r+3], c));
          hb_d[4*r+c] = 11'(bf(pb[4*r], pb[4*r+1], pb[4*r+2], pb[4*r+3], c));
        end
    // S2: column transforms with weighted magnitude sums, or sum of squared differences
    always_comb begin
      int ca, cb, sse;
      logic [31:0] ta, tb;
      ta = '0;
      tb = '0;
      sse = 0;
      for (int u = 0; u < 4; u++)
        for (int v = 0; v < 4; v++) begin
          ca = bf(int'(ha_q[v]), int'(ha_q[4+v]), int'(ha_q[8+v]), int'(ha_q[12+v]), u);
          cb = bf(int'(hb_q[v]), int'(hb_q[4+v]), int'(hb_q[8+v]), int'(hb_q[12+v]), u);
          ta = ta + 32'(w_q[16*(4*u+v) +: 16]) * 32'(ca < 0 ? -ca : ca);
          tb = tb + 32'(w_q[16*(4*u+v) +: 16]) * 32'(cb < 0 ? -cb : cb);
          sse = sse + int'(ha_q[4*u+v]) * int'(ha_q[4*u+v]);
        end
      s2a_d = mode_q ? 32'(sse) : ta;
      s2b_d = mode_q ? '0 : tb;
    end
    // S3: scaled absolute texture difference, SSE passes straight through
    assign res_d = mode_q ? s2a_q : (s2a_q > s2b_q ? s2a_q - s2b_q : s2b_q - s2a_q) >> 5;
    // Lane stage registers
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ha_q <= '{default: '0};
        hb_q <= '{default: '0};
        s2a_q <= '0;
        s2b_q <= '0;
        res_q <= '0;
      end else begin
        ha_q <= ha_d;
        hb_q <= hb_d;
        s2a_q <= s2a_d;
        s2b_q <= s2b_d;
        res_q <= res_d;
      end
  end
  // Sum of this cycle's lane results feeding the accumulator
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + lane_res[i];
  end
endmodule

// File: tb/tb_disto_nxn_pipe.sv
// tb_disto_nxn_pipe: randomized and directed checks of disto_nxn_pipe against a matrix-form reference model
module tb_disto_nxn_pipe;
  logic clk = 0, rst_n = 0, mode = 0;
  logic start [4];
  logic [2047:0] ina16, inb16;
  logic [511:0] ina8, inb8;
  logic [127:0] ina4, inb4;
  logic [255:0] wb;
  logic [31:0] sum_o [4];
  logic busy_o [4], done_o [4];
  int checks = 0, errors = 0;
  int pa [16][16], pb [16][16], wv [16];
  int lat [4] = '{20, 8, 8, 5};
  int bsz [4] = '{16, 16, 8, 4};
  bit md;
  always #5 clk = ~clk;
  disto_nxn_pipe #(.BLOCK_SIZE(16), .LANES(1)) u0 (.clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode), .ina(ina16), .inb(inb16), .w(wb), .sum(sum_o[0]), .busy(busy_o[0]), .done(done_o[0]));
  disto_nxn_pipe #(.BLOCK_SIZE(16), .LANES(4)) u1 (.clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode), .ina(ina16), .inb(inb16), .w(wb), .sum(sum_o[1]), .busy(busy_o[1]), .done(done_o[1]));
  disto_nxn_pipe #(.BLOCK_SIZE(8), .LANES(1)) u2 (.clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode), .ina(ina8), .inb(inb8), .w(wb), .sum(sum_o[2]), .busy(busy_o[2]), .done(done_o[2]));
  disto_nxn_pipe #(.BLOCK_SIZE(4), .LANES(1)) u3 (.clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode), .ina(ina4), .inb(inb4), .w(wb), .sum(sum_o[3]), .busy(busy_o[3]), .done(done_o[3]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int hm(input int i, input int j);
    return i == 0 ? 1 : i == 1 ? (j < 2 ? 1 : -1) : i == 2 ? ((j == 0 || j == 3) ? 1 : -1) : (j % 2 == 0 ? 1 : -1);
  endfunction
  function automatic logic [31:0] model(input int b, input bit m);
    longint tot, ta, tb, ca, cb, d;
    tot = 0;
    if (m) begin
      for (int r = 0; r < b; r++)
        for (int c = 0; c < b; c++) begin
          d = pa[r][c] - pb[r][c];
          tot += d * d;
        end
      return 32'(tot);
    end
    for (int tr = 0; tr < b / 4; tr++)
      for (int tc = 0; tc < b / 4; tc++) begin
        ta = 0;
        tb = 0;
        for (int u = 0; u < 4; u++)
          for (int v = 0; v < 4; v++) begin
            ca = 0;
            cb = 0;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++) begin
                ca += hm(u, r) * hm(v, c) * pa[4*tr+r][4*tc+c];
                cb += hm(u, r) * hm(v, c) * pb[4*tr+r][4*tc+c];
              end
            ta += wv[4*u+v] * (ca < 0 ? -ca : ca);
            tb += wv[4*u+v] * (cb < 0 ? -cb : cb);
          end
        tot += (ta > tb ? ta - tb : tb - ta) / 32;
      end
    return 32'(tot);
  endfunction
  task automatic put();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        ina16[8*(r*16+c) +: 8] = 8'(pa[r][c]);
        inb16[8*(r*16+c) +: 8] = 8'(pb[r][c]);
        if (r < 8 && c < 8) begin
          ina8[8*(r*8+c) +: 8] = 8'(pa[r][c]);
          inb8[8*(r*8+c) +: 8] = 8'(pb[r][c]);
        end
        if (r < 4 && c < 4) begin
          ina4[8*(r*4+c) +: 8] = 8'(pa[r][c]);
          inb4[8*(r*4+c) +: 8] = 8'(pb[r][c]);
        end
      end
    for (int k = 0; k < 16; k++) wb[16*k +: 16] = 16'(wv[k]);
    mode = md;
  endtask
  task automatic scramble();
    for (int i = 0; i < 64; i++) begin
      ina16[32*i +: 32] = $urandom;
      inb16[32*i +: 32] = $urandom;
    end
    for (int i = 0; i < 16; i++) begin
      ina8[32*i +: 32] = $urandom;
      inb8[32*i +: 32] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      ina4[32*i +: 32] = $urandom;
      inb4[32*i +: 32] = $urandom;
    end
    for (int i = 0; i < 8; i++) wb[32*i +: 32] = $urandom;
    mode = 1'($urandom);
  endtask
  task automatic set_all(input int a, input int b, input int wval);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        pa[r][c] = a;
        pb[r][c] = b;
      end
    for (int k = 0; k < 16; k++) wv[k] = wval;
  endtask
  task automatic rnd_fill();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        pa[r][c] = int'($urandom_range(0, 255));
        pb[r][c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : pa[r][c] ^ int'($urandom_range(0, 3));
      end
    for (int k = 0; k < 16; k++) wv[k] = int'($urandom_range(0, 65535));
  endtask
  task automatic go(input int d);
    start[d] = 1;
    @(posedge clk);
    #1;
    start[d] = 0;
    chk("busy_after_accept", 32'(busy_o[d]), 1);
    scramble();
  endtask
  task automatic finish_op(input int d, input logic [31:0] exp, input string tag, input int poke);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      start[d] = (n == poke);
      if (n == poke) scramble();
    end while (!done_o[d] && n < 100);
    start[d] = 0;
    chk({tag, "_lat"}, 32'(n), 32'(lat[d]));
    chk({tag, "_sum"}, sum_o[d], exp);
    chk({tag, "_idle"}, 32'(busy_o[d]), 0);
  endtask
  task automatic run(input int d, input string tag, input logic [31:0] exp, input int poke);
    put();
    go(d);
    finish_op(d, exp, tag, poke);
  endtask
  initial begin
    int n_done;
    for (int i = 0; i < 4; i++) start[i] = 0;
    md = 0;
    set_all(0, 0, 0);
    put();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", sum_o[0], 0);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_done", 32'(done_o[0]), 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    set_all(255, 0, 65535);
    run(0, "full_range", 133691392, 0);
    put();
    go(0);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_sum", sum_o[0], 0);
    chk("abort_busy", 32'(busy_o[0]), 0);
    @(negedge clk) rst_n = 1;
    n_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_o[0]) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 0);
    run(0, "after_abort", 133691392, 0);
    rnd_fill();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) pb[r][c] = pa[r][c];
    run(0, "zero_disto", 0, 0);
    set_all(0, 0, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) pa[r][c] = 16;
    wv[0] = 1;
    run(0, "tile_l1", 8, 0);
    run(1, "tile_l4", 8, 0);
    set_all(10, 0, 0);
    md = 1;
    run(0, "sse16", 25600, 0);
    run(2, "sse8", 6400, 0);
    run(3, "sse4", 1600, 0);
    md = 0;
    set_all(255, 0, 65535);
    run(0, "busy_poke", 133691392, 5);
    run(1, "busy_poke_l4", 133691392, 3);
    md = 1;
    set_all(10, 0, 0);
    put();
    go(0);
    finish_op(0, 25600, "b2b_first", 0);
    set_all(3, 1, 0);
    put();
    go(0);
    chk("b2b_hold", sum_o[0], 25600);
    finish_op(0, 1024, "b2b_second", 0);
    repeat (6) begin
      rnd_fill();
      md = 1'($urandom);
      for (int d = 0; d < 4; d++) run(d, md ? "rand_sse" : "rand_tdisto", model(bsz[d], md), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
